// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter that lets NUM_REQ producers share the single write
// port of one sync_fifo. One producer is granted at a time for a burst of up
// to MAX_BURST beats. A grant is released early when the producer drops
// valid. Writes stall, and are never dropped, while the FIFO reports full.
//
// Handshake: a beat transfers on a cycle where req_valid[i] && req_ready[i].
// req_ready is at most one-hot. It can only be high for the granted
// requester, and only while fifo_full is low. A producer holds valid and data
// stable until it sees ready. Dropping valid while granted forfeits the rest
// of the burst.
//
// Configuration macro: FIFO_WR_ARB_TAG_EN
//   defined   : fifo_wr_data = {grant_id, payload} (FIFO_W = ID_W+DATA_WIDTH)
//   undefined : fifo_wr_data = payload             (FIFO_W = DATA_WIDTH)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester valid                          [NUM_REQ]
//   req_data      packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-requester accept (one-hot or zero)       [NUM_REQ]
//   fifo_full     sync_fifo full flag
//   fifo_wr_en    sync_fifo write enable
//   fifo_wr_data  sync_fifo write data                         [FIFO_W]
//   grant_vld     a grant is active (also the FSM state: 1 = GRANT)
//   grant_id      index of the granted requester               [ID_W]
// ----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = $clog2(NUM_REQ),
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int FIFO_W     = DATA_WIDTH + ID_W
`else
  localparam int FIFO_W     = DATA_WIDTH
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_W-1:0]             fifo_wr_data,
  output logic                          grant_vld,
  output logic [ID_W-1:0]               grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic              cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;
  logic              beat;
  logic              release_grant;
  logic              any_valid;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   ptr_after;

  // Signals of the currently granted requester
  assign cur_valid = req_valid[grant_id];
  assign cur_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

  assign beat          = (state == GRANT) && cur_valid && !fifo_full;
  assign release_grant = (state == GRANT) &&
                         (!cur_valid || (beat && (beat_cnt == CNT_W'(MAX_BURST - 1))));

  // Explicit wrap compare so non-power-of-two NUM_REQ works
  assign ptr_after = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // Round-robin pick: scan offsets from high to low so the lowest offset from
  // rr_ptr (the first set bit searching upward) is the one left in win_id.
  always_comb begin
    int idx;
    idx       = 0;
    win_id    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx[ID_W-1:0]]) begin
        win_id    = idx[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid)     state_nxt = GRANT;
      GRANT:   if (release_grant) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: winner capture, beat counting, pointer advance on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= win_id;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_grant) begin
            rr_ptr   <= ptr_after;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // FSM outputs: purely combinational, no registered data stage
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    grant_vld    = (state == GRANT);
    if (state == GRANT) begin
      req_ready[grant_id] = !fifo_full;
      if (beat) begin
        fifo_wr_en = 1'b1;
`ifdef FIFO_WR_ARB_TAG_EN
        fifo_wr_data = {grant_id, cur_data};
`else
        fifo_wr_data = cur_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter. Producers are modelled as queues of
// payloads; the reference model tracks "who owns the write port, how many
// beats it used, and where the next search starts" in plain integers and
// predicts every cycle's outputs. Predicted writes go into exp_q and are
// popped against the DUT's actual writes.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int ID_W       = $clog2(NUM_REQ);
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int FIFO_W     = DATA_WIDTH + ID_W;
`else
  localparam int FIFO_W     = DATA_WIDTH;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- DUT ----------------
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [FIFO_W-1:0]             fifo_wr_data;
  logic                          grant_vld;
  logic [ID_W-1:0]               grant_id;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_vld   (grant_vld),
    .grant_id    (grant_id)
  );

  // ---------------- scoreboard state ----------------
  int n_vec;
  int n_miscmp;
  logic [FIFO_W-1:0]     exp_q[$];
  logic [DATA_WIDTH-1:0] prod_q[NUM_REQ][$];
  logic [NUM_REQ-1:0]    presenting;
  logic [NUM_REQ-1:0]    fire;
  int gap_pct, full_pct, full_start, full_len, cyc;

  // Reference model: owner of the port, beats used, next search start
  bit m_busy;
  int m_owner;
  int m_used;
  int m_next;
  bit m_beat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FIFO_W-1:0] expect_word(input int id, input logic [DATA_WIDTH-1:0] d);
`ifdef FIFO_WR_ARB_TAG_EN
    return {id[ID_W-1:0], d};
`else
    if (id < 0) return '0;
    return d;
`endif
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < NUM_REQ; i++) if (prod_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_used  = 0;
    m_next  = 0;
    m_beat  = 1'b0;
  endtask

  // Called mid-cycle (negedge): predict and compare this cycle's outputs
  task automatic check_cycle();
    logic [NUM_REQ-1:0] e_ready;
    logic               e_wr;
    e_ready = '0;
    e_wr    = 1'b0;
    m_beat  = m_busy && req_valid[m_owner] && !fifo_full;
    if (m_busy) e_ready[m_owner] = !fifo_full;
    if (m_beat) begin
      e_wr = 1'b1;
      exp_q.push_back(expect_word(m_owner, req_data[m_owner*DATA_WIDTH +: DATA_WIDTH]));
    end
    check("grant_vld", grant_vld, m_busy);
    check("grant_id", grant_id, m_owner);
    check("req_ready", req_ready, e_ready);
    check("wr_en", fifo_wr_en, e_wr);
    check("ready_onehot", $countones(req_ready) <= 1, 1);
    check("no_write_when_full", fifo_wr_en && fifo_full, 0);
    if (!m_busy) check("idle_wr_data", fifo_wr_data, 0);
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) check("write_expected", exp_q.size() > 0, 1);
      else                   check("wr_data", fifo_wr_data, exp_q.pop_front());
    end
    fire = req_valid & req_ready;
  endtask

  // Called just after the rising edge: move the model by one clock
  task automatic model_advance();
    if (!m_busy) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (m_next + k) % NUM_REQ;
        if (req_valid[c]) begin
          m_owner = c;
          m_used  = 0;
          m_busy  = 1'b1;
          break;
        end
      end
    end else begin
      if (m_beat) m_used++;
      if (!req_valid[m_owner] || m_used == MAX_BURST) begin
        m_busy = 1'b0;
        m_next = (m_owner + 1) % NUM_REQ;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fire[i] && prod_q[i].size() > 0) begin
        void'(prod_q[i].pop_front());
        presenting[i] = 1'b0;
      end
      if (!presenting[i] && prod_q[i].size() > 0 && $urandom_range(0, 99) >= gap_pct)
        presenting[i] = 1'b1;
      req_valid[i] = presenting[i];
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = presenting[i] ? prod_q[i][0]
                                                           : DATA_WIDTH'($urandom);
    end
    fifo_full = (cyc >= full_start && cyc < full_start + full_len) ||
                ($urandom_range(0, 99) < full_pct);
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    model_advance();
    cyc++;
    drive_inputs();
  endtask

  task automatic start_scenario(input int gap, input int fpct, input int fstart, input int flen);
    gap_pct    = gap;
    full_pct   = fpct;
    full_start = fstart;
    full_len   = flen;
    cyc        = 0;
    fire       = '0;
    drive_inputs();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int left;
    left = budget;
    while ((!queues_empty() || m_busy || req_valid != '0) && left > 0) begin
      run_cycle();
      left--;
    end
    run_cycle();
    check({tag, "_drained"}, (!queues_empty() || m_busy), 0);
    check({tag, "_exp_q_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec      = 0;
    n_miscmp   = 0;
    presenting = '0;
    fire       = '0;
    req_valid  = '0;
    req_data   = '0;
    fifo_full  = 1'b0;
    gap_pct    = 0;
    full_pct   = 0;
    full_start = 0;
    full_len   = 0;
    cyc        = 0;
    model_reset();
    rst_n = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant_vld", grant_vld, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single producer, burst split: 4 beats, bubble, 2 beats
    for (int i = 0; i < 6; i++) prod_q[2].push_back(8'hA0 + 8'(i));
    start_scenario(0, 0, 0, 0);
    run_until_idle("burst_split", 40);

    // Round robin with every requester continuously valid
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < 8; j++) prod_q[i].push_back(8'($urandom));
    start_scenario(0, 0, 0, 0);
    run_until_idle("round_robin", 80);

    // Full back-pressure: 2 beats, 5 full cycles, 2 more beats
    for (int i = 0; i < 4; i++) prod_q[1].push_back(8'h10 + 8'(i));
    start_scenario(0, 0, 3, 5);
    run_until_idle("backpressure", 40);

    // Early release: one beat from req 3 leaves the pointer at 0
    prod_q[3].push_back(8'h5C);
    start_scenario(0, 0, 0, 0);
    run_until_idle("early_release", 20);

    // Pointer at 0: req 1 must beat req 2; leaves pointer at 3
    prod_q[1].push_back(8'h7E);
    prod_q[2].push_back(8'h33);
    start_scenario(0, 0, 0, 0);
    run_until_idle("ptr_order", 20);

    // Reset mid-burst: grant to req 0, reset after beat 2
    for (int i = 0; i < 4; i++) prod_q[0].push_back(8'hC0 + 8'(i));
    start_scenario(0, 0, 0, 0);
    repeat (3) run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant_vld", grant_vld, 0);
    check("async_rst_grant_id", grant_id, 0);
    check("async_rst_wr_en", fifo_wr_en, 0);
    check("async_rst_req_ready", req_ready, 0);
    check("async_rst_wr_data", fifo_wr_data, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Req 3 also waits: with the pointer back at 0, req 0 wins first
    prod_q[3].push_back(8'h3A);
    start_scenario(0, 0, 0, 0);
    run_until_idle("after_reset", 40);

    // Randomized traffic with gaps and random full
    start_scenario(30, 25, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      if (n % 50 == 0)
        for (int i = 0; i < NUM_REQ; i++)
          if (prod_q[i].size() == 0)
            repeat ($urandom_range(0, 10)) prod_q[i].push_back(8'($urandom));
      run_cycle();
    end
    full_pct = 0;
    gap_pct  = 0;
    run_until_idle("random", 400);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
